// File: rtl/pip_wb_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it to the 32x32 integer
// register file, and serves two decode read ports with same-cycle bypass.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module pip_wb_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          alu_out_p,
  input  logic [XLEN-1:0]          dmem_out_p,
  input  logic                     wb_sel_p,
  input  logic [$clog2(NREGS)-1:0] rd_p,
  input  logic                     rdEn_p,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
`ifdef WB_RETIRE_CNT_EN
  input  logic                     retire_clr,
  output logic [31:0]              retire_cnt,
`endif
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_valid
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  assign wb_data  = wb_sel_p ? dmem_out_p : alu_out_p;
  assign wb_valid = rdEn_p && (rd_p != AW'(0));

  // x0 is excluded by wb_valid, so entry 0 keeps its reset value forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[rd_p] <= wb_data;
    end
  end

  // Reads return 0 while reset is held, even if a bypass candidate is present
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n && (rs1 != AW'(0))) begin
      rdata1 = (wb_valid && (rd_p == rs1)) ? wb_data : regs[rs1];
    end
    if (rst_n && (rs2 != AW'(0))) begin
      rdata2 = (wb_valid && (rd_p == rs2)) ? wb_data : regs[rs2];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Clear has priority over increment; wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire_clr) begin
      retire_cnt <= '0;
    end else if (wb_valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
